// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared types and constants for the iterative multiply/divide unit
package mult_div_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);

  // Quotient reported for a divide by zero
  localparam logic [MD_WIDTH-1:0] MD_DIVZERO_Q = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_RUN,
    ST_DIV_RUN,
    ST_FIX,
    ST_DONE
  } md_state_e;

endpackage

// File: rtl/mult_div_if.sv
// rtl/mult_div_if.sv - start/operand/result bundle between control unit and multiply/divide unit
// master: control unit (drives mult_start, div_start, a, b)
// slave : mult_div_unit (drives hi_out, lo_out, mult_done, div_done, busy, div_zero)
interface mult_div_if
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);

  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             mult_done;
  logic             div_done;
  logic             busy;
  logic             div_zero;

  modport master (
    output mult_start, div_start, a, b,
    input  hi_out, lo_out, mult_done, div_done, busy, div_zero
  );

  modport slave (
    input  mult_start, div_start, a, b,
    output hi_out, lo_out, mult_done, div_done, busy, div_zero
  );

endinterface

// File: rtl/mult_div_sign_fix.sv
// rtl/mult_div_sign_fix.sv - conditional two's-complement negate of two lanes or one joined double-width value
// x_hi/x_lo  in : operand lanes
// join_wide  in : treat {x_hi,x_lo} as one 2*WIDTH value negated by neg_lo
// neg_hi     in : negate x_hi (independent lanes only)
// neg_lo     in : negate x_lo, or the joined value
// y_hi/y_lo  out: results
module mult_div_sign_fix
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] x_hi,
  input  logic [WIDTH-1:0] x_lo,
  input  logic             join_wide,
  input  logic             neg_hi,
  input  logic             neg_lo,
  output logic [WIDTH-1:0] y_hi,
  output logic [WIDTH-1:0] y_lo
);

  logic [2*WIDTH-1:0] wide_neg;

  always_comb begin
    wide_neg = -{x_hi, x_lo};
    if (join_wide) begin
      {y_hi, y_lo} = neg_lo ? wide_neg : {x_hi, x_lo};
    end else begin
      y_hi = neg_hi ? -x_hi : x_hi;
      y_lo = neg_lo ? -x_lo : x_lo;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply/divide, one bit per cycle, optional MULT_DIV_DIVZERO_EN fast divide-by-zero
// clk   in : clock
// reset in : synchronous active-high reset
// md    slave modport of mult_div_if: starts and operands in; hi/lo, done pulses, busy, div_zero out
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic      clk,
  input logic      reset,
  mult_div_if.slave md
);

  localparam int CNT_W = (WIDTH == MD_WIDTH) ? MD_CNT_W : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  // mult: {partial high, remaining multiplier}; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;

  mult_div_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .x_hi      (md.a),
    .x_lo      (md.b),
    .join_wide (1'b0),
    .neg_hi    (md.a[WIDTH-1]),
    .neg_lo    (md.b[WIDTH-1]),
    .y_hi      (abs_a),
    .y_lo      (abs_b)
  );

  // Remainder follows the dividend; quotient and product follow sign(a)^sign(b)
  mult_div_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .x_hi      (acc[2*WIDTH-1:WIDTH]),
    .x_lo      (acc[WIDTH-1:0]),
    .join_wide (~op_div),
    .neg_hi    (sign_a),
    .neg_lo    (sign_a ^ sign_b),
    .y_hi      (fix_hi),
    .y_lo      (fix_lo)
  );

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opb};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      a_raw  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (md.mult_start || md.div_start) begin
            acc    <= {{WIDTH{1'b0}}, abs_a};
            opb    <= abs_b;
            a_raw  <= md.a;
            sign_a <= md.a[WIDTH-1];
            sign_b <= md.b[WIDTH-1];
            b_zero <= (md.b == '0);
            cnt    <= '0;
            op_div <= ~md.mult_start;
            if (md.mult_start) begin
              state <= ST_MUL_RUN;
            end else begin
`ifdef MULT_DIV_DIVZERO_EN
              state <= (md.b == '0) ? ST_FIX : ST_DIV_RUN;
`else
              state <= ST_DIV_RUN;
`endif
            end
          end
        end
        ST_MUL_RUN: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= ST_FIX;
        end
        ST_DIV_RUN: begin
          // Borrow out of the trial subtract means the divisor did not fit: restore
          if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else                  acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_div && b_zero) begin
            hi_r <= a_raw;
            lo_r <= WIDTH'($signed(MD_DIVZERO_Q));
          end else begin
            hi_r <= fix_hi;
            lo_r <= fix_lo;
          end
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md.hi_out    = hi_r;
  assign md.lo_out    = lo_r;
  assign md.busy      = (state != ST_IDLE);
  assign md.mult_done = (state == ST_DONE) && !op_div;
  assign md.div_done  = (state == ST_DONE) && op_div;
`ifdef MULT_DIV_DIVZERO_EN
  assign md.div_zero  = (state == ST_DONE) && op_div && b_zero;
`else
  assign md.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;

`ifdef MULT_DIV_DIVZERO_EN
  localparam bit DZ_ON = 1'b1;
`else
  localparam bit DZ_ON = 1'b0;
`endif
  localparam int LAT_FULL = 34;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: timeline of one accepted operation, results from plain signed arithmetic
  int          cyc = 0;
  int          m_start = -100;
  int          m_end = -100;
  bit          m_div = 1'b0;
  bit          m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, n_hi = '0, n_lo = '0;
  longint      sa, sb, p, q, r;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_start = -100; m_end = -100; m_div = 1'b0; m_dz = 1'b0;
    end else begin
      if (cyc == m_end) begin
        m_hi = n_hi; m_lo = n_lo;
      end
      if ((bus.mult_start || bus.div_start) && (cyc - 1 > m_end)) begin
        sa = longint'($signed(bus.a));
        sb = longint'($signed(bus.b));
        m_div = !bus.mult_start;
        m_dz = m_div && (bus.b == 32'd0);
        if (!m_div) begin
          p = sa * sb;
          n_hi = p[63:32]; n_lo = p[31:0];
        end else if (m_dz) begin
          n_hi = bus.a; n_lo = 32'hFFFF_FFFF;
        end else begin
          q = sa / sb; r = sa % sb;
          n_hi = r[31:0]; n_lo = q[31:0];
        end
        m_start = cyc;
        m_end = cyc + ((m_dz && DZ_ON) ? 1 : LAT_FULL - 1);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic done_e;
      done_e = (cyc == m_end);
      chk("flags", {60'd0, bus.busy, bus.mult_done, bus.div_done, bus.div_zero},
          {60'd0, (cyc >= m_start && cyc <= m_end), done_e && !m_div, done_e && m_div,
           done_e && m_div && m_dz && DZ_ON});
      chk("result", {bus.hi_out, bus.lo_out}, {m_hi, m_lo});
    end
  end

  task automatic run_op(input bit do_mul, input bit do_div, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input int elat, input bit edz,
                        input string nm);
    int n;
    int busy_n;
    @(negedge clk);
    bus.mult_start = do_mul; bus.div_start = do_div; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.mult_start = 1'b0; bus.div_start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    n = 1; busy_n = 0;
    while (!(bus.mult_done || bus.div_done) && n < 60) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      n++;
    end
    if (bus.busy) busy_n++;
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_busy_cycles"}, busy_n, elat);
    chk({nm, "_kind"}, {bus.mult_done, bus.div_done, bus.div_zero}, {do_mul, !do_mul, edz});
    chk({nm, "_hilo"}, {bus.hi_out, bus.lo_out}, {eh, el});
    @(negedge clk);
    chk({nm, "_after"}, {bus.busy, bus.mult_done, bus.div_done}, 3'b000);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [4];
    sp[0] = 32'h0; sp[1] = 32'h8000_0000; sp[2] = 32'hFFFF_FFFF; sp[3] = 32'h1;
    if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 3)];
    if ($urandom_range(0, 3) == 0) return 32'($signed(8'($urandom)));
    return $urandom;
  endfunction

  initial begin
    int mcnt;
    int dcnt;
    logic [63:0] seen;
    bus.mult_start = 1'b0; bus.div_start = 1'b0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {bus.busy, bus.mult_done, bus.div_done, bus.div_zero, bus.hi_out, bus.lo_out}, '0);
    reset = 1'b0;

    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT_FULL, 0, "mul_mixed");
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, LAT_FULL, 0, "mul_minmin");
    run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, LAT_FULL, 0, "mul_m1m1");
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_FULL, 0, "div_signed");
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, LAT_FULL, 0, "div_ovf");
    run_op(0, 1, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, DZ_ON ? 2 : LAT_FULL, DZ_ON, "div_zero");
    run_op(1, 1, 32'd6, 32'd7, 32'h0, 32'd42, LAT_FULL, 0, "both_start");

    // Reset at iteration 10 of a divide
    @(negedge clk);
    bus.div_start = 1'b1; bus.a = 32'd1000; bus.b = 32'd7;
    @(negedge clk);
    bus.div_start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid", {bus.busy, bus.mult_done, bus.div_done, bus.div_zero, bus.hi_out, bus.lo_out}, '0);
    run_op(1, 0, 32'd3, 32'd5, 32'h0, 32'd15, LAT_FULL, 0, "mul_after_rst");

    // Second start at cycle 5 of a busy multiply is ignored
    @(negedge clk);
    bus.mult_start = 1'b1; bus.a = 32'd1234; bus.b = 32'hFFFF_FFFB;
    @(negedge clk);
    bus.mult_start = 1'b0;
    repeat (4) @(negedge clk);
    bus.div_start = 1'b1; bus.a = 32'd9; bus.b = 32'd3;
    @(negedge clk);
    bus.div_start = 1'b0;
    mcnt = 0; dcnt = 0; seen = '0;
    repeat (45) begin
      @(negedge clk);
      if (bus.mult_done) begin mcnt++; seen = {bus.hi_out, bus.lo_out}; end
      if (bus.div_done) dcnt++;
    end
    chk("ignored_start_pulses", {mcnt[31:0], dcnt[31:0]}, {32'd1, 32'd0});
    chk("ignored_start_hilo", seen, 64'hFFFF_FFFF_FFFF_E7E6);
    chk("ignored_start_hold", {bus.hi_out, bus.lo_out}, 64'hFFFF_FFFF_FFFF_E7E6);

    // Random traffic: starts land anywhere, including while busy and in DONE
    for (int i = 0; i < 1500; i++) begin
      int rr;
      @(negedge clk);
      rr = $urandom_range(0, 11);
      bus.mult_start = (rr == 0) || (rr == 2);
      bus.div_start = (rr == 1) || (rr == 2) || (rr == 3);
      bus.a = pick();
      bus.b = pick();
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    bus.mult_start = 1'b0; bus.div_start = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
